// File: rtl/POLI_types_pkg.sv
// Shared types and constants for the POLI control-register responders.
// Holds the CRC-32 constants and FSM state type used by crc32_engine.
package POLI_types_pkg;

  localparam int unsigned WORD_SIZE = 32;

  localparam logic [WORD_SIZE-1:0] CRC_POLY      = 32'h04C1_1DB7;
  localparam logic [WORD_SIZE-1:0] CRC_POLY_REFL = 32'hEDB8_8320;
  localparam logic [WORD_SIZE-1:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [WORD_SIZE-1:0] CRC_XOROUT    = 32'hFFFF_FFFF;

  typedef enum logic {CRC_IDLE, CRC_BUSY} crc_state_t;

endpackage

// File: rtl/crc32_step.sv
// Combinational CRC-32 fold of BITS_PER_CYCLE data bits into an accumulator.
// Normal (MSB-first) mode exists only when CRC_ORIENT_EN is defined.
module crc32_step
  import POLI_types_pkg::*;
#(
  parameter int unsigned WORD_SIZE      = 32,
  parameter int unsigned BITS_PER_CYCLE = 8
) (
  input  logic [WORD_SIZE-1:0]      acc,
  input  logic [BITS_PER_CYCLE-1:0] data,
  input  logic                      orient,
  output logic [WORD_SIZE-1:0]      acc_next
);

  logic                      fb;
  logic [BITS_PER_CYCLE-1:0] ds;

  // Data bits are consumed by shifting a local copy so only constant indices are used.
  always_comb begin
    acc_next = acc;
    ds       = data;
    fb       = 1'b0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
`ifdef CRC_ORIENT_EN
      if (!orient) begin
        fb       = acc_next[WORD_SIZE-1] ^ ds[BITS_PER_CYCLE-1];
        ds       = ds << 1;
        acc_next = (acc_next << 1) ^ (fb ? CRC_POLY : '0);
      end else
`endif
      begin
        fb       = acc_next[0] ^ ds[0];
        ds       = ds >> 1;
        acc_next = (acc_next >> 1) ^ (fb ? CRC_POLY_REFL : '0);
      end
    end
  end

`ifndef CRC_ORIENT_EN
  logic unused_orient;
  assign unused_orient = orient;
`endif

endmodule

// File: rtl/crc32_engine.sv
// CRC-32 engine folding one word per start, BITS_PER_CYCLE bits per clock.
// Optional macro CRC_ORIENT_EN adds MSB-first mode selected by crc_orient[0].
module crc32_engine
  import POLI_types_pkg::*;
#(
  parameter int unsigned WORD_SIZE      = 32,
  parameter int unsigned BITS_PER_CYCLE = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [WORD_SIZE-1:0] crc_data_in,
  input  logic                 crc_start,
  input  logic                 crc_reset,
  input  logic [WORD_SIZE-1:0] crc_orient,
  output logic [WORD_SIZE-1:0] crc_out,
  output logic                 crc_ready
);

  localparam int unsigned STEPS = WORD_SIZE / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = $clog2(STEPS) + 1;

  crc_state_t                state;
  logic [WORD_SIZE-1:0]      acc;
  logic [WORD_SIZE-1:0]      acc_next;
  logic [WORD_SIZE-1:0]      sreg;
  logic [WORD_SIZE-1:0]      sreg_next;
  logic [BITS_PER_CYCLE-1:0] slice;
  logic [CNT_W-1:0]          cnt;
  logic                      orient_q;
  logic                      unused_orient;

`ifdef CRC_ORIENT_EN
  assign slice         = orient_q ? sreg[BITS_PER_CYCLE-1:0] : sreg[WORD_SIZE-1 -: BITS_PER_CYCLE];
  assign sreg_next     = orient_q ? (sreg >> BITS_PER_CYCLE) : (sreg << BITS_PER_CYCLE);
  assign unused_orient = ^crc_orient[WORD_SIZE-1:1];
`else
  assign orient_q      = 1'b1;
  assign slice         = sreg[BITS_PER_CYCLE-1:0];
  assign sreg_next     = sreg >> BITS_PER_CYCLE;
  assign unused_orient = ^crc_orient;
`endif

  crc32_step #(
    .WORD_SIZE      (WORD_SIZE),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .acc      (acc),
    .data     (slice),
    .orient   (orient_q),
    .acc_next (acc_next)
  );

  // Finalisation is combinational so an async reset yields crc_out = 0 at once.
  assign crc_out = acc ^ CRC_XOROUT;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= CRC_IDLE;
      acc       <= CRC_INIT;
      sreg      <= '0;
      cnt       <= '0;
      crc_ready <= 1'b1;
`ifdef CRC_ORIENT_EN
      orient_q  <= 1'b1;
`endif
    end else if (crc_reset) begin
      state     <= CRC_IDLE;
      acc       <= CRC_INIT;
      cnt       <= '0;
      crc_ready <= 1'b1;
    end else begin
      case (state)
        CRC_IDLE: begin
          if (crc_start) begin
            sreg      <= crc_data_in;
            cnt       <= '0;
            state     <= CRC_BUSY;
            crc_ready <= 1'b0;
`ifdef CRC_ORIENT_EN
            orient_q  <= crc_orient[0];
`endif
          end
        end
        CRC_BUSY: begin
          acc  <= acc_next;
          sreg <= sreg_next;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_W'(STEPS - 1)) begin
            state     <= CRC_IDLE;
            crc_ready <= 1'b1;
          end
        end
        default: state <= CRC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc32_engine.sv
// Directed self-checking bench for crc32_engine at BITS_PER_CYCLE = 8, 1 and 32.
// Three instances share stimulus; expected CRCs are hand constants or a bitwise model.
module tb_crc32_engine;

  logic        CLK;
  logic        RST;
  logic [31:0] crc_data_in;
  logic        crc_start;
  logic        crc_reset;
  logic [31:0] crc_orient;
  logic [31:0] out8, out1, out32;
  logic        rdy8, rdy1, rdy32;

  int checks = 0;
  int errors = 0;

  crc32_engine u8 (
    .CLK(CLK), .RST(RST), .crc_data_in(crc_data_in), .crc_start(crc_start),
    .crc_reset(crc_reset), .crc_orient(crc_orient), .crc_out(out8), .crc_ready(rdy8)
  );

  crc32_engine #(.WORD_SIZE(32), .BITS_PER_CYCLE(1)) u1 (
    .CLK(CLK), .RST(RST), .crc_data_in(crc_data_in), .crc_start(crc_start),
    .crc_reset(crc_reset), .crc_orient(crc_orient), .crc_out(out1), .crc_ready(rdy1)
  );

  crc32_engine #(.WORD_SIZE(32), .BITS_PER_CYCLE(32)) u32 (
    .CLK(CLK), .RST(RST), .crc_data_in(crc_data_in), .crc_start(crc_start),
    .crc_reset(crc_reset), .crc_orient(crc_orient), .crc_out(out32), .crc_ready(rdy32)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_all_ready(input string tag);
    int n;
    n = 0;
    while (!(rdy8 && rdy1 && rdy32) && n < 60) begin
      tick();
      n++;
    end
    check(tag, {31'd0, rdy8 && rdy1 && rdy32}, 32'd1);
  endtask

  function automatic logic [31:0] ref_refl(input logic [31:0] a, input logic [31:0] w);
    logic [31:0] r;
    logic [31:0] d;
    r = a;
    d = w;
    for (int i = 0; i < 32; i++) begin
      if (r[0] ^ d[0]) r = (r >> 1) ^ 32'hEDB8_8320;
      else             r = r >> 1;
      d = d >> 1;
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_norm(input logic [31:0] a, input logic [31:0] w);
    logic [31:0] r;
    logic [31:0] d;
    r = a;
    d = w;
    for (int i = 0; i < 32; i++) begin
      if (r[31] ^ d[31]) r = (r << 1) ^ 32'h04C1_1DB7;
      else               r = r << 1;
      d = d << 1;
    end
    return r;
  endfunction

  // Starts one word and records, per instance, the edge count at which ready returns.
  task automatic run_word(input string tag, input logic [31:0] w, input logic [31:0] exp_out);
    int lat8, lat1, lat32;
    lat8 = 0; lat1 = 0; lat32 = 0;
    crc_data_in = w;
    crc_start   = 1'b1;
    tick();
    crc_start   = 1'b0;
    for (int e = 2; e <= 40; e++) begin
      tick();
      if (lat8  == 0 && rdy8)  lat8  = e;
      if (lat1  == 0 && rdy1)  lat1  = e;
      if (lat32 == 0 && rdy32) lat32 = e;
    end
    check({tag, " lat8"},  lat8,  32'd5);
    check({tag, " lat1"},  lat1,  32'd33);
    check({tag, " lat32"}, lat32, 32'd2);
    check({tag, " out8"},  out8,  exp_out);
    check({tag, " out1"},  out1,  exp_out);
    check({tag, " out32"}, out32, exp_out);
  endtask

  task automatic pulse_crc_reset();
    crc_reset = 1'b1;
    tick();
    crc_reset = 1'b0;
  endtask

  initial begin
    logic [31:0] model;
    logic [31:0] w;

    RST         = 1'b1;
    crc_data_in = '0;
    crc_start   = 1'b0;
    crc_reset   = 1'b0;
    crc_orient  = 32'h0000_0001;
    #1;
    check("reset ready", {31'd0, rdy8}, 32'd1);
    check("reset out",   out8, 32'h0000_0000);
    tick();
    RST = 1'b0;
    tick();

    // Zero word: ready low for 4 cycles then the known CRC of four zero bytes.
    crc_data_in = 32'h0000_0000;
    crc_start   = 1'b1;
    tick();
    crc_start   = 1'b0;
    check("zero busy0", {31'd0, rdy8}, 32'd0);
    for (int i = 1; i < 4; i++) begin
      tick();
      check($sformatf("zero busy%0d", i), {31'd0, rdy8}, 32'd0);
    end
    tick();
    check("zero ready", {31'd0, rdy8}, 32'd1);
    check("zero out8",  out8, 32'h2144_DF1C);
    wait_all_ready("zero wait");
    check("zero out1",  out1,  32'h2144_DF1C);
    check("zero out32", out32, 32'h2144_DF1C);

    // Asynchronous reset in the middle of a BUSY operation.
    pulse_crc_reset();
    crc_start = 1'b1;
    tick();
    crc_start = 1'b0;
    tick();
    RST = 1'b1;
    #1;
    check("async rst ready", {31'd0, rdy8}, 32'd1);
    check("async rst out",   out8, 32'h0000_0000);
    tick();
    RST = 1'b0;
    tick();

    // All-ones word.
    crc_data_in = 32'hFFFF_FFFF;
    crc_start   = 1'b1;
    tick();
    crc_start   = 1'b0;
    wait_all_ready("ones wait");
    check("ones out8",  out8,  32'hFFFF_FFFF);
    check("ones out1",  out1,  32'hFFFF_FFFF);
    check("ones out32", out32, 32'hFFFF_FFFF);

    // A second start while BUSY must be ignored.
    pulse_crc_reset();
    crc_data_in = 32'h0000_0000;
    crc_start   = 1'b1;
    tick();
    crc_data_in = 32'hFFFF_FFFF;
    tick();
    crc_start   = 1'b0;
    wait_all_ready("busy start wait");
    check("busy start out8",  out8,  32'h2144_DF1C);
    check("busy start out1",  out1,  32'h2144_DF1C);
    check("busy start out32", out32, 32'h2144_DF1C);

    // crc_reset wins over crc_start in the same cycle.
    crc_data_in = 32'h0000_0000;
    crc_reset   = 1'b1;
    crc_start   = 1'b1;
    tick();
    crc_reset   = 1'b0;
    crc_start   = 1'b0;
    check("rst+start ready", {31'd0, rdy8}, 32'd1);
    check("rst+start out",   out8, 32'h0000_0000);
    tick();
    check("rst+start idle",  {31'd0, rdy8}, 32'd1);
    check("rst+start hold",  out8, 32'h0000_0000);

    // Abort on the 2nd BUSY cycle, then a clean restart.
    crc_start = 1'b1;
    tick();
    crc_start = 1'b0;
    tick();
    crc_reset = 1'b1;
    tick();
    crc_reset = 1'b0;
    check("abort ready", {31'd0, rdy8}, 32'd1);
    check("abort out8",  out8, 32'h0000_0000);
    check("abort out1",  out1, 32'h0000_0000);
    crc_start = 1'b1;
    tick();
    crc_start = 1'b0;
    wait_all_ready("abort restart wait");
    check("abort restart out8", out8, 32'h2144_DF1C);

    // Back-to-back random words against the reflected reference model.
    pulse_crc_reset();
    model = 32'hFFFF_FFFF;
    for (int k = 0; k < 5; k++) begin
      w     = $urandom;
      model = ref_refl(model, w);
      run_word($sformatf("refl word%0d", k), w, model ^ 32'hFFFF_FFFF);
    end

`ifdef CRC_ORIENT_EN
    // MSB-first mode; orient changes during BUSY must not matter.
    crc_orient = 32'h0000_0000;
    pulse_crc_reset();
    model = 32'hFFFF_FFFF;
    for (int k = 0; k < 4; k++) begin
      w     = $urandom;
      model = ref_norm(model, w);
      crc_orient = 32'h0000_0000;
      fork
        begin
          @(posedge CLK);
          #2 crc_orient = 32'h0000_0001;
        end
      join_none
      run_word($sformatf("norm word%0d", k), w, model ^ 32'hFFFF_FFFF);
    end
    crc_orient = 32'h0000_0001;
`else
    model = ref_norm(model, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/crc32_engine.md
Name: crc32_engine

Overview:
- CRC-32 responder behind the control register's crc_* signals. The control register drives crc_data_in, crc_start, crc_reset and crc_orient; this block drives crc_out and crc_ready.
- Folds one 32-bit word per start into a running CRC accumulator, processing BITS_PER_CYCLE bits per clock.
- Exposes the finalized CRC. Software streams words through the control register and reads crc_out once crc_ready is high.

Parameters:
- WORD_SIZE, 32, data and CRC width; must equal the package WORD_SIZE.
- BITS_PER_CYCLE, 8, bits folded per clock; legal values are 1, 2, 4, 8, 16, 32.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- crc_data_in  input  WORD_SIZE  word to fold; sampled only on an accepted start.
- crc_start  input  1  single-cycle request to fold crc_data_in.
- crc_reset  input  1  synchronous re-initialisation of the accumulator.
- crc_orient  input  WORD_SIZE  mode bits; only bit 0 is used (see Optional Feature); other bits reserved, ignored.
- crc_out  output  WORD_SIZE  finalized CRC = accumulator XOR CRC_XOROUT.
- crc_ready  output  1  high when idle and crc_out is valid.

Behaviour:
- Reset values (RST high, asynchronous): state IDLE; accumulator = CRC_INIT (0xFFFFFFFF); crc_out = 0x00000000; crc_ready = 1; step counter = 0.
- States: IDLE, BUSY. N = WORD_SIZE / BITS_PER_CYCLE steps per word.
- IDLE + crc_start: latch crc_data_in into a shift register; capture the orientation mode; counter = 0; go to BUSY. crc_ready drops on the next cycle.
- BUSY: each edge folds BITS_PER_CYCLE bits into the accumulator and increments the counter. After the N-th fold, go to IDLE.
- crc_ready is high again on the cycle after the N-th fold, so start-to-ready latency is N+1 edges (5 for default). crc_out is valid whenever crc_ready = 1.
- crc_start while BUSY: ignored; no queueing; the latched word is unaffected.
- crc_reset: has priority over crc_start in the same cycle. In any state it sets accumulator = CRC_INIT, counter = 0, state = IDLE. A BUSY operation is aborted and its partial result discarded.
- crc_reset while IDLE: crc_out becomes 0x00000000 on the next cycle.
- Reflected mode (default): polynomial 0xEDB88320; the data shift register shifts right and feeds its LSB first.
- Fold rule per bit: fb = acc[0] ^ d; acc = (acc >> 1) ^ (fb ? POLY_REFL : 0).
- Inputs are not registered beyond the start latch. crc_data_in changes after acceptance have no effect.
- Counter width is $clog2(N)+1; it never wraps mid-word.

Optional Feature:
- Macro: CRC_ORIENT_EN.
- Defined: crc_orient[0] is captured at start.
  - 1 selects reflected mode (above).
  - 0 selects normal MSB-first mode: poly 0x04C11DB7; data shifts left, MSB first; fb = acc[31] ^ d; acc = (acc << 1) ^ (fb ? POLY : 0).
  - crc_orient[0] changes during BUSY are ignored.
- Undefined: reflected mode only; crc_orient is entirely ignored and no normal-mode logic is synthesised.

Decomposition:
- POLI_types_pkg gains:
  - CRC_POLY (0x04C11DB7), CRC_POLY_REFL (0xEDB88320), CRC_INIT (0xFFFFFFFF), CRC_XOROUT (0xFFFFFFFF).
  - typedef enum logic {CRC_IDLE, CRC_BUSY} crc_state_t.
- Sub-module crc32_step: purely combinational unrolled fold of BITS_PER_CYCLE bits.
  - Inputs: acc, data slice, orient. Output: next acc.
  - Instanced once in crc32_engine and unit-testable on its own.

Test Plan:
- Reset: assert RST mid-BUSY -> crc_ready = 1 and crc_out = 0x00000000 immediately, without waiting for a clock edge.
- Zero word, reflected: reset, start with 0x00000000 -> ready low 4 cycles, then crc_out = 0x2144DF1C.
- All-ones word: reset, start with 0xFFFFFFFF -> crc_out = 0xFFFFFFFF.
- Busy and reset collisions:
  - Start with 0x00000000, pulse start with 0xFFFFFFFF during BUSY -> second start ignored; crc_out = 0x2144DF1C.
  - crc_reset and crc_start asserted in the same cycle -> stays IDLE; crc_out = 0x00000000.
- Abort: start with 0x00000000, assert crc_reset on the 2nd BUSY cycle -> IDLE next cycle, crc_out = 0x00000000; then start with 0x00000000 -> crc_out = 0x2144DF1C.
- Multi-word and parameter sweep: feed random words back-to-back, each start waiting for ready, with BITS_PER_CYCLE = 1 and 32 -> results match the software reference model; ready latency = 33 and 2 edges respectively. With CRC_ORIENT_EN and orient[0] = 0, results match the MSB-first model.
